// File: rtl/packed_serializer_if.sv
// Load handshake and serial output bundle for packed_serializer.
// load_data takes its packed ranges from the base and direction parameters.
interface packed_serializer_if #(
   parameter int ROWS     = 3,
   parameter int COLS     = 5,
   parameter int ROW_BASE = 0,
   parameter int COL_BASE = 0,
   parameter int ROW_ASC  = 0,
   parameter int COL_ASC  = 0
);
   localparam int ROW_L = (ROW_ASC != 0) ? ROW_BASE : ROW_BASE + ROWS - 1;
   localparam int ROW_R = (ROW_ASC != 0) ? ROW_BASE + ROWS - 1 : ROW_BASE;
   localparam int COL_L = (COL_ASC != 0) ? COL_BASE : COL_BASE + COLS - 1;
   localparam int COL_R = (COL_ASC != 0) ? COL_BASE + COLS - 1 : COL_BASE;

   logic                                load_valid;
   logic                                load_ready;
   logic [ROW_L:ROW_R][COL_L:COL_R]     load_data;
   logic                                shift_en;
   logic                                out;
   logic                                out_valid;
   logic                                out_last;

   modport master (
      output load_valid, load_data, shift_en,
      input  load_ready, out, out_valid, out_last
   );

   modport slave (
      input  load_valid, load_data, shift_en,
      output load_ready, out, out_valid, out_last
   );
endinterface

// File: rtl/packed_serializer.sv
// Parallel-to-serial converter for a ROWS x COLS packed word.
// Bits leave highest logical index first; a new word may follow the last bit with no gap.
module packed_serializer #(
   parameter int ROWS     = 3,
   parameter int COLS     = 5,
   parameter int ROW_BASE = 0,
   parameter int COL_BASE = 0,
   parameter int ROW_ASC  = 0,
   parameter int COL_ASC  = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   packed_serializer_if.slave   bus
);
   localparam int N  = ROWS * COLS;
   localparam int CW = $clog2(N + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state_reg;
   logic [N-1:0]    flat;
   logic [N-1:0]    sreg_reg;
   logic [CW-1:0]   remaining_reg;
   logic            out_reg;
   logic            out_valid_reg;
   logic            out_last_reg;
   logic            load_fire;

   // flat[k] is the k-th bit to be emitted, addressed by numeric index so
   // the declared direction of either range does not matter.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_flat
         assign flat[gi] = bus.load_data[ROW_BASE + ROWS - 1 - gi / COLS]
                                        [COL_BASE + COLS - 1 - gi % COLS];
      end
   endgenerate

   assign bus.load_ready = !reset &&
                           ((state_reg == IDLE) || (out_last_reg && bus.shift_en));
   assign load_fire      = bus.load_valid && bus.load_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         sreg_reg      <= '0;
         remaining_reg <= '0;
         out_reg       <= 1'b0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
      end else if (load_fire) begin
         state_reg     <= SHIFT;
         out_reg       <= flat[0];
         sreg_reg      <= flat >> 1;
         remaining_reg <= CW'(N - 1);
         out_valid_reg <= 1'b1;
         out_last_reg  <= (N == 1);
      end else if (state_reg == SHIFT && bus.shift_en) begin
         if (out_last_reg) begin
            state_reg     <= IDLE;
            out_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
         end else begin
            out_reg       <= sreg_reg[0];
            sreg_reg      <= sreg_reg >> 1;
            remaining_reg <= remaining_reg - CW'(1);
            out_last_reg  <= (remaining_reg == CW'(1));
         end
      end
   end

   assign bus.out       = out_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_last  = out_last_reg;
endmodule
